// File: rtl/i2s_tx_gen_if.sv
// Sample-pair handshake between an audio source and the i2s_tx_gen transmitter.
// The source drives the sample pair with in_valid. The transmitter answers with in_ready.
`timescale 1ns/1ps
interface i2s_tx_gen_if #(
  parameter int IN_WIDTH = 10
) ();
  logic [IN_WIDTH-1:0] in_left;
  logic [IN_WIDTH-1:0] in_right;
  logic                in_valid;
  logic                in_ready;

  modport master (
    output in_left,
    output in_right,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_left,
    input  in_right,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/i2s_tx_gen.sv
// i2s_tx_gen: I2S / left-justified stereo serial transmitter.
// BCK and LRCK are divided down from clk. A one-entry holding register accepts
// sample pairs. At each frame start the pair is volume-shifted and loaded into a
// 2*SLOT_BITS shift register.
// Optional feature macro I2S_MCLK_EN: when it is defined, a free-running MCLK divider
// (MCLK_HALF clk cycles per half-period) is built. When it is undefined, mclk is tied to 0.
`timescale 1ns/1ps
module i2s_tx_gen #(
  parameter int IN_WIDTH     = 10,
  parameter int SLOT_BITS    = 32,
  parameter int BCK_HALF     = 12,
  parameter int VOLUME_WIDTH = 4,
  parameter int MCLK_HALF    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fmt,
  input  logic [VOLUME_WIDTH-1:0] volume,
  i2s_tx_gen_if.slave             s_if,
  input  logic                    underrun_clr,
  output logic                    underrun,
  output logic                    mclk,
  output logic                    bck,
  output logic                    lrck,
  output logic                    sdata
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST      = DW'(BCK_HALF - 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] LJ_HI_START   = CW'(SLOT_BITS);
  localparam logic [CW-1:0] I2S_HI_START  = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] I2S_HI_END    = CW'(FRAME_BITS - 2);

  // Catch illegal parameter combinations at elaboration time.
  if (IN_WIDTH > SLOT_BITS) begin : g_chk_width
    $error("i2s_tx_gen: IN_WIDTH must not exceed SLOT_BITS");
  end
  if (BCK_HALF < 2) begin : g_chk_bck
    $error("i2s_tx_gen: BCK_HALF must be at least 2");
  end
  if (MCLK_HALF < 1) begin : g_chk_mclk
    $error("i2s_tx_gen: MCLK_HALF must be at least 1");
  end

  // Left-align the sample in its slot, then attenuate it with an arithmetic shift.
  // A shift count that reaches the slot width leaves only sign bits.
  function automatic logic [SLOT_BITS-1:0] make_slot(
    input logic signed [IN_WIDTH-1:0]     s,
    input logic        [VOLUME_WIDTH-1:0] v
  );
    logic signed [SLOT_BITS-1:0] a;
    a = SLOT_BITS'(s);
    a = a <<< (SLOT_BITS - IN_WIDTH);
    if (int'(v) >= SLOT_BITS) begin
      return {SLOT_BITS{a[SLOT_BITS-1]}};
    end
    return a >>> v;
  endfunction

  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic                  bck_q, bck_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  started_q, started_d;
  logic                  fmt_q, fmt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  lrck_q, lrck_d;
  logic                  sdata_q, sdata_d;
  logic                  hold_full_q, hold_full_d;
  logic [IN_WIDTH-1:0]   hold_left_q, hold_left_d;
  logic [IN_WIDTH-1:0]   hold_right_q, hold_right_d;
  logic                  underrun_q, underrun_d;

  logic div_tc;
  logic bck_fall;
  logic frame_start;
  logic fmt_eff;
  logic xfer;

  // Next-state logic for the divider, bit counter, framing, holding register and underrun flag.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    bck_d        = bck_q;
    bit_cnt_d    = bit_cnt_q;
    started_d    = started_q;
    fmt_d        = fmt_q;
    shift_d      = shift_q;
    lrck_d       = lrck_q;
    sdata_d      = sdata_q;
    hold_full_d  = hold_full_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    fmt_eff      = fmt_q;

    div_tc      = (div_cnt_q == DIV_LAST);
    div_cnt_d   = div_tc ? '0 : div_cnt_q + DW'(1);
    if (div_tc) begin
      bck_d = ~bck_q;
    end
    bck_fall    = div_tc && bck_q;
    // The first fall after reset and every counter wrap open a new frame.
    frame_start = bck_fall && (!started_q || (bit_cnt_q == CNT_LAST));

    if (bck_fall) begin
      started_d = 1'b1;
      bit_cnt_d = frame_start ? '0 : bit_cnt_q + CW'(1);
      if (frame_start) begin
        fmt_eff = fmt;
        fmt_d   = fmt;
        shift_d = hold_full_q ?
                  {make_slot(hold_left_q, volume), make_slot(hold_right_q, volume)} :
                  '0;
      end else begin
        shift_d = shift_q << 1;
      end
      if (fmt_eff) begin
        // Left-justified: the bit for this slot position is the new MSB.
        sdata_d = shift_d[FRAME_BITS-1];
        lrck_d  = (bit_cnt_d >= LJ_HI_START);
      end else begin
        // I2S: send the bit one position late. At bit 0 the old MSB is still the
        // previous frame's right LSB.
        sdata_d = shift_q[FRAME_BITS-1];
        lrck_d  = (bit_cnt_d >= I2S_HI_START) && (bit_cnt_d <= I2S_HI_END);
      end
    end

    // A frame start sees the holding register as it was before this cycle's transfer.
    xfer = s_if.in_valid && !hold_full_q;
    if (frame_start && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    if (xfer) begin
      hold_full_d  = 1'b1;
      hold_left_d  = s_if.in_left;
      hold_right_d = s_if.in_right;
    end

    // When a clear and a new underrun arrive in the same cycle, the set wins.
    underrun_d = (underrun_q && !underrun_clr) || (frame_start && !hold_full_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q    <= '0;
      bck_q        <= 1'b0;
      bit_cnt_q    <= '0;
      started_q    <= 1'b0;
      fmt_q        <= 1'b0;
      shift_q      <= '0;
      lrck_q       <= 1'b0;
      sdata_q      <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bck_q        <= bck_d;
      bit_cnt_q    <= bit_cnt_d;
      started_q    <= started_d;
      fmt_q        <= fmt_d;
      shift_q      <= shift_d;
      lrck_q       <= lrck_d;
      sdata_q      <= sdata_d;
      hold_full_q  <= hold_full_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      underrun_q   <= underrun_d;
    end
  end

  assign s_if.in_ready = !hold_full_q;
  assign underrun      = underrun_q;
  assign bck           = bck_q;
  assign lrck          = lrck_q;
  assign sdata         = sdata_q;

`ifdef I2S_MCLK_EN
  localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_HALF - 1);

  logic [MW-1:0] mclk_cnt_q, mclk_cnt_d;
  logic          mclk_q, mclk_d;

  // Free-running MCLK divider that toggles every MCLK_HALF clk cycles.
  always_comb begin
    mclk_cnt_d = mclk_cnt_q + MW'(1);
    mclk_d     = mclk_q;
    if (mclk_cnt_q == MCLK_LAST) begin
      mclk_cnt_d = '0;
      mclk_d     = ~mclk_q;
    end
  end

  // MCLK divider registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mclk_cnt_q <= '0;
      mclk_q     <= 1'b0;
    end else begin
      mclk_cnt_q <= mclk_cnt_d;
      mclk_q     <= mclk_d;
    end
  end

  assign mclk = mclk_q;
`else
  assign mclk = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_tx_gen.sv
// Directed self-checking bench for i2s_tx_gen at default parameters.
// I2S_MCLK_EN selects which mclk behaviour is expected.
`timescale 1ns/1ps
module tb_i2s_tx_gen;

  localparam int BCK_HALF = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fmt;
  logic [3:0] volume;
  logic       underrun_clr;
  logic       underrun;
  logic       mclk;
  logic       bck;
  logic       lrck;
  logic       sdata;

  i2s_tx_gen_if #(.IN_WIDTH(10)) s_if ();

  i2s_tx_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fmt          (fmt),
    .volume       (volume),
    .s_if         (s_if),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .mclk         (mclk),
    .bck          (bck),
    .lrck         (lrck),
    .sdata        (sdata)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   fall_idx = -1;
  logic fell     = 1'b0;
  logic bck_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clk edge and sample the outputs 1 ns later. A BCK falling edge
  // increments the bench's own bit counter.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    fell     = bck_prev && !bck;
    bck_prev = bck;
    if (fell) fall_idx++;
  endtask

  task automatic wait_fall();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!fell && n < 4 * BCK_HALF);
    if (!fell) begin
      checks++;
      failures++;
      $display("FAIL bck_fall_timeout observed=no_fall expected=fall_within_%0d_clk", 4 * BCK_HALF);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  // Capture one whole frame from its bit-0 fall: sd[63-i] and lr[i] hold the sdata
  // and lrck values seen at bit i.
  task automatic capture(output logic [63:0] sd, output logic [63:0] lr, output int start_cyc);
    do wait_fall(); while (fall_idx % 64 != 0);
    start_cyc = cyc;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) wait_fall();
      sd[63-i] = sdata;
      lr[i]    = lrck;
    end
  endtask

  initial begin
    logic [63:0] sd, lr;
    int          st0, st1, st2;
    int          xfers, ready_hi;
    logic        pend;

    // Reset state
    reset_n           = 1'b0;
    fmt               = 1'b1;
    volume            = 4'd0;
    underrun_clr      = 1'b0;
    s_if.in_valid     = 1'b1;
    s_if.in_left      = 10'h1FF;
    s_if.in_right     = 10'h200;
    repeat (3) tick();
    chk("rst_bck", bck, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_in_ready", s_if.in_ready, 1);
    chk("rst_mclk", mclk, 0);

    // Test 1: LJ, volume 0, sample pushed before the first frame
    reset_n  = 1'b1;
    cyc      = 0;
    fall_idx = -1;
    tick();
    chk("t1_ready_after_push", s_if.in_ready, 0);
    s_if.in_valid = 1'b0;
    repeat (10) tick();
    chk("t1_bck_low_clk11", bck, 0);
    tick();
    chk("t1_bck_rise_clk12", bck, 1);
    capture(sd, lr, st0);
    chk("t1_first_frame_clk", st0, 24);
    chk("t1_lj_data", sd, 64'h7FC00000_80000000);
    chk("t1_lj_lrck", lr, 64'hFFFFFFFF_00000000);
    chk("t1_underrun", underrun, 0);

    // Test 2: I2S, left = -1, volume 2
    s_if.in_left  = 10'h3FF;
    s_if.in_right = 10'h000;
    s_if.in_valid = 1'b1;
    fmt           = 1'b0;
    volume        = 4'd2;
    tick();
    s_if.in_valid = 1'b0;
    chk("t2_ready_after_push", s_if.in_ready, 0);
    capture(sd, lr, st1);
    chk("t1_frame_len", st1 - st0, 1536);
    chk("t2_i2s_data", sd, 64'h7FF80000_00000000);
    chk("t2_i2s_lrck", lr, 64'h7FFFFFFF_80000000);
    chk("t2_underrun", underrun, 0);

    // Test 3: two starved frames, clear, then recovery
    capture(sd, lr, st2);
    chk("t3_starved1_data", sd, 64'h0);
    chk("t3_underrun_set", underrun, 1);
    capture(sd, lr, st2);
    chk("t3_starved2_data", sd, 64'h0);
    chk("t3_underrun_held", underrun, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("t3_underrun_cleared", underrun, 0);
    s_if.in_left  = 10'h155;
    s_if.in_right = 10'h2AA;
    s_if.in_valid = 1'b1;
    fmt           = 1'b1;
    volume        = 4'd0;
    tick();
    s_if.in_valid = 1'b0;
    capture(sd, lr, st2);
    chk("t3_recover_data", sd, 64'h55400000_AA800000);
    chk("t3_recover_lrck", lr, 64'hFFFFFFFF_00000000);
    chk("t3_recover_underrun", underrun, 0);

    // A clear that coincides with a new underrun: the set wins
    underrun_clr = 1'b1;
    wait_fall();
    underrun_clr = 1'b0;
    chk("t3_set_wins", underrun, 1);

    // Test 4: in_valid held high for three frame periods
    s_if.in_left  = 10'h0AA;
    s_if.in_right = 10'h3FF;
    s_if.in_valid = 1'b1;
    xfers    = 0;
    ready_hi = 0;
    for (int t = 1; t <= 3 * 1536; t++) begin
      pend = s_if.in_valid && s_if.in_ready;
      tick();
      if (pend) xfers++;
      if (s_if.in_ready) ready_hi++;
    end
    s_if.in_valid = 1'b0;
    chk("t4_transfers", xfers, 3);
    chk("t4_ready_high_cycles", ready_hi, 3);

    // Test 5: reset in the middle of a frame at bit_cnt 40 with bck high
    do wait_fall(); while (fall_idx % 64 != 40);
    repeat (13) tick();
    chk("t5_pre_bck", bck, 1);
    chk("t5_pre_lrck", lrck, 1);
    chk("t5_pre_sdata", sdata, 1);
    chk("t5_pre_underrun", underrun, 1);
    reset_n = 1'b0;
    tick();
    chk("t5_rst_bck", bck, 0);
    chk("t5_rst_lrck", lrck, 0);
    chk("t5_rst_sdata", sdata, 0);
    chk("t5_rst_in_ready", s_if.in_ready, 1);
    chk("t5_rst_underrun", underrun, 0);
    tick();
    reset_n  = 1'b1;
    cyc      = 0;
    fall_idx = -1;
    wait_fall();
    chk("t5_first_frame_clk", cyc, 24);
    chk("t5_underrun", underrun, 1);
    chk("t5_sdata_zero", sdata, 0);
    chk("t5_lrck_left", lrck, 0);

    // Test 6: mclk
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef I2S_MCLK_EN
      chk("t6_mclk_toggle", mclk, 64'(cyc % 2));
`else
      chk("t6_mclk_tied", mclk, 0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_tx_gen.md
Name: i2s_tx_gen

Overview:
Parametrised I2S/left-justified stereo serial transmitter, the next generation of the FM receiver's audio output stage.
- Generates BCK, LRCK and serial data from clk using parametrised dividers and slot width.
- Accepts stereo samples through a valid/ready handshake into a one-entry holding register; the transmitter sets the frame rate.
- Applies a volume shift, selects the framing format at run time and flags underruns.

Parameters:
IN_WIDTH, 10, signed input sample width; must be <= SLOT_BITS.
SLOT_BITS, 32, bits per channel slot; frame = 2*SLOT_BITS BCK periods.
BCK_HALF, 12, clk cycles per BCK half-period (>=2).
VOLUME_WIDTH, 4, width of volume attenuation code.
MCLK_HALF, 1, clk cycles per MCLK half-period (used only with I2S_MCLK_EN).

Ports:
clk  in  1  system clock (73.728 MHz nominal).
reset_n  in  1  synchronous, active-low reset.
fmt  in  1  0 = I2S (1-bit delay), 1 = left-justified; sampled at frame start.
volume  in  VOLUME_WIDTH  attenuation: arithmetic right shift count.
in_left  in  IN_WIDTH  signed left sample.
in_right  in  IN_WIDTH  signed right sample.
in_valid  in  1  sample pair valid.
in_ready  out  1  holding register empty.
underrun_clr  in  1  clears the underrun flag.
underrun  out  1  sticky; a frame started with no sample.
mclk  out  1  master clock (tied 0 without I2S_MCLK_EN).
bck  out  1  bit clock.
lrck  out  1  word clock; 0 = left.
sdata  out  1  serial data, MSB first, changes on BCK falling edge.

Behaviour:
- Reset (synchronous, reset_n=0 at a clk edge) forces: bck=0, lrck=0, sdata=0, underrun=0, in_ready=1, mclk=0. Divider, bit counter, holding register and shift register are all cleared. Reset mid-frame aborts the frame immediately, with no completion.
- Divider: counts 0..BCK_HALF-1 and toggles bck on terminal count. The first rise is at clk BCK_HALF after reset release; the first fall (first frame start) is at 2*BCK_HALF.
- Bit counter bit_cnt: 0..2*SLOT_BITS-1, advanced on every BCK falling edge, wrapping to 0. A wrap (or the first fall after reset) is a frame start.
- Frame start actions:
  - Latch fmt.
  - If the holding register is full: load the shift register as {L,R}, where each slot = (sample << (SLOT_BITS-IN_WIDTH)) >>> volume (sign-preserving), then empty the holding register.
  - If the holding register is empty: load all zeros and set underrun.
- Handshake: in_ready = holding register empty; transfer on in_valid && in_ready.
  - Transfer and frame start in the same cycle: the frame takes the *previous* state, so an empty register means underrun. The new sample lands in the holding register for the next frame.
- underrun_clr clears underrun. If it coincides with a new underrun event, set wins.
- LJ mode:
  - sdata = frame bit bit_cnt (MSB of left at bit_cnt 0).
  - lrck = 1 for bit_cnt in [SLOT_BITS, 2*SLOT_BITS-1].
- I2S mode:
  - sdata = frame bit bit_cnt-1; at bit_cnt 0 it outputs the previous frame's right LSB (0 after reset).
  - lrck = 1 for bit_cnt in [SLOT_BITS-1, 2*SLOT_BITS-2].
- lrck and sdata are registered and update only on BCK falling edges, in the same clk cycle bck goes 0.
- volume is sampled at frame start. If volume >= SLOT_BITS, the slot is all sign bits.
- Frame period = 4*SLOT_BITS*BCK_HALF clk cycles (1536 at defaults = 48 kHz).

Optional Feature:
Macro I2S_MCLK_EN.
- Defined: mclk toggles every MCLK_HALF clk cycles, free-running from reset release (default 36.864 MHz), reset to 0.
- Undefined: no mclk divider is built; mclk is constant 0.

Test Plan:
1. Defaults, LJ, volume 0, in_left=10'h1FF, in_right=10'h200 pushed before the first frame -> left slot 0x7FC00000, right slot 0x80000000; lrck rises at BCK fall 32; frame length 1536 clk.
2. I2S, in_left=-1, volume 2 -> left slot 0xFFF00000; MSB appears one BCK after the lrck fall; lrck rises at bit_cnt 31.
3. No in_valid for 2 frames -> sdata all 0, underrun=1 and held. Pulse underrun_clr -> underrun=0. Push a sample -> next frame carries it.
4. in_valid held high continuously -> exactly one transfer per 1536 clk; in_ready low between the transfer and the next frame start.
5. Assert reset_n=0 at bit_cnt 40 -> next clk bck=lrck=sdata=0, in_ready=1. After release, the first frame starts 24 clk later with zeros and underrun set.
6. With I2S_MCLK_EN, MCLK_HALF=1 -> mclk period 2 clk; without the macro -> mclk stays 0.
